// File: rtl/lv_pkg.sv
// Shared types for the LV-side ADC readback scheduler.
// Contents: scheduler FSM state encoding and ADC channel identifiers.
// No ports; imported by the scheduler, its arbiter and the link interface users.
package lv_pkg;

  typedef enum logic [1:0] {
    ADC_SCH_IDLE,
    ADC_SCH_REQ,
    ADC_SCH_WAIT,
    ADC_SCH_DONE
  } adc_sch_state_e;

  localparam logic ADC_CH1 = 1'b0;
  localparam logic ADC_CH2 = 1'b1;

endpackage

// File: rtl/lv_adc_rd_sched_if.sv
// One-wire link (OWT) request/response bundle between the ADC readback scheduler and the tx/rx engine.
// Ports: o_owt_req/o_owt_ch (scheduler -> link), i_owt_ack, i_owt_rsp_vld/_err/_data (link -> scheduler).
// Modports: master = scheduler side, slave = link engine side. Signal names keep the scheduler's view.
interface lv_adc_rd_sched_if #(
  parameter int DATA_W = 8
);
  logic              o_owt_req;
  logic              o_owt_ch;
  logic              i_owt_ack;
  logic              i_owt_rsp_vld;
  logic              i_owt_rsp_err;
  logic [DATA_W-1:0] i_owt_rsp_data;

  modport master (
    output o_owt_req, o_owt_ch,
    input  i_owt_ack, i_owt_rsp_vld, i_owt_rsp_err, i_owt_rsp_data
  );

  modport slave (
    input  o_owt_req, o_owt_ch,
    output i_owt_ack, i_owt_rsp_vld, i_owt_rsp_err, i_owt_rsp_data
  );
endinterface

// File: rtl/lv_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, grants the requester not served last.
// Ports: clk, rst_n (async, active low), req[1:0], gnt_en (grant taken this cycle), gnt_idx.
// gnt_idx is combinational; the last-served pointer only moves when gnt_en is high.
module lv_rr_arb2
  import lv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       gnt_en,
  output logic       gnt_idx
);

  logic last_q;

  always_comb begin
    gnt_idx = ADC_CH1;
    if (req == 2'b11) begin
      gnt_idx = ~last_q;
    end else if (req[1]) begin
      gnt_idx = ADC_CH2;
    end
  end

  // Pointer starts as "ADC2 served last" so ADC1 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ADC_CH2;
    end else if (gnt_en) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/lv_adc_rd_sched.sv
// ADC readback scheduler: arbitrates ADC1/ADC2 over the shared OWT link, one transaction in flight.
// Ports: i_clk/i_rst_n, i_sched_en, i_adcN_req -> o_adcN_ack, owt link bundle, o_adcN_data/_vld, o_err.
// Option: define LV_ADC_RD_SCHED_RETRY_EN to retry a failed transaction once before reporting o_err.
module lv_adc_rd_sched
  import lv_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TMO_CYC = 200,
  parameter int TMO_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sched_en,
  input  logic              i_adc1_req,
  input  logic              i_adc2_req,
  output logic              o_adc1_ack,
  output logic              o_adc2_ack,
  lv_adc_rd_sched_if.master owt,
  output logic [DATA_W-1:0] o_adc1_data,
  output logic [DATA_W-1:0] o_adc2_data,
  output logic              o_adc1_vld,
  output logic              o_adc2_vld,
  output logic              o_err
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  adc_sch_state_e   state_q, state_d;
  logic             ch_q;
  logic             err_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             gnt_idx;
  logic             grant;
  logic             in_wait;
  logic             tmo_hit;
  logic             rsp_ok;
  logic             fail;
  logic             fail_final;

  assign grant   = (state_q == ADC_SCH_IDLE) & i_sched_en & (i_adc1_req | i_adc2_req);
  assign in_wait = (state_q == ADC_SCH_WAIT);
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
  assign rsp_ok  = in_wait & owt.i_owt_rsp_vld & ~owt.i_owt_rsp_err;
  // A response in the timeout cycle takes priority over the timeout.
  assign fail    = in_wait & (owt.i_owt_rsp_vld ? owt.i_owt_rsp_err : tmo_hit);

  lv_rr_arb2 u_arb (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .req     ({i_adc2_req, i_adc1_req}),
    .gnt_en  (grant),
    .gnt_idx (gnt_idx)
  );

`ifdef LV_ADC_RD_SCHED_RETRY_EN
  // First failure goes back to REQ for the same channel; only the second one is final.
  logic retry_q;
  assign fail_final = fail & retry_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      retry_q <= 1'b0;
    end else if (grant) begin
      retry_q <= 1'b0;
    end else if (fail) begin
      retry_q <= 1'b1;
    end
  end
`else
  assign fail_final = fail;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ADC_SCH_IDLE: if (grant) state_d = ADC_SCH_REQ;
      ADC_SCH_REQ:  if (owt.i_owt_ack) state_d = ADC_SCH_WAIT;
      ADC_SCH_WAIT: begin
        if (rsp_ok || fail_final) begin
          state_d = ADC_SCH_DONE;
        end else if (fail) begin
          state_d = ADC_SCH_REQ;
        end
      end
      ADC_SCH_DONE: state_d = ADC_SCH_IDLE;
      default:      state_d = ADC_SCH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ADC_SCH_IDLE;
      ch_q    <= ADC_CH1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        ch_q  <= gnt_idx;
        err_q <= 1'b0;
      end else if (fail_final) begin
        err_q <= 1'b1;
      end
    end
  end

  // Cleared whenever not waiting, so each WAIT entry (including a retry) starts from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt_q <= '0;
    end else if (!in_wait) begin
      tmo_cnt_q <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_adc1_data <= '0;
      o_adc2_data <= '0;
      o_adc1_vld  <= 1'b0;
      o_adc2_vld  <= 1'b0;
    end else if (rsp_ok) begin
      if (ch_q == ADC_CH2) begin
        o_adc2_data <= owt.i_owt_rsp_data;
        o_adc2_vld  <= 1'b1;
      end else begin
        o_adc1_data <= owt.i_owt_rsp_data;
        o_adc1_vld  <= 1'b1;
      end
    end
  end

  assign owt.o_owt_req = (state_q == ADC_SCH_REQ);
  assign owt.o_owt_ch  = ch_q;
  assign o_adc1_ack    = (state_q == ADC_SCH_DONE) & (ch_q == ADC_CH1);
  assign o_adc2_ack    = (state_q == ADC_SCH_DONE) & (ch_q == ADC_CH2);
  assign o_err         = (state_q == ADC_SCH_DONE) & err_q;

endmodule

// File: tb/tb_lv_adc_rd_sched.sv
// Directed bench for lv_adc_rd_sched: scoreboard of expected transactions, checked at each ack.
// Drives the OWT link side through the interface; samples and drives on the falling clock edge.
// Honours LV_ADC_RD_SCHED_RETRY_EN by expecting one extra link request per failed transaction.
module tb_lv_adc_rd_sched;

  localparam int DATA_W  = 8;
  localparam int TMO_CYC = 200;
`ifdef LV_ADC_RD_SCHED_RETRY_EN
  localparam int N_TRY = 2;
`else
  localparam int N_TRY = 1;
`endif

  typedef struct packed {
    logic              ch;
    logic              err;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_sched_en;
  logic              i_adc1_req;
  logic              i_adc2_req;
  logic              o_adc1_ack;
  logic              o_adc2_ack;
  logic [DATA_W-1:0] o_adc1_data;
  logic [DATA_W-1:0] o_adc2_data;
  logic              o_adc1_vld;
  logic              o_adc2_vld;
  logic              o_err;

  lv_adc_rd_sched_if #(.DATA_W(DATA_W)) owt ();

  lv_adc_rd_sched #(.DATA_W(DATA_W), .TMO_CYC(TMO_CYC), .TMO_W(8)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_sched_en  (i_sched_en),
    .i_adc1_req  (i_adc1_req),
    .i_adc2_req  (i_adc2_req),
    .o_adc1_ack  (o_adc1_ack),
    .o_adc2_ack  (o_adc2_ack),
    .owt         (owt),
    .o_adc1_data (o_adc1_data),
    .o_adc2_data (o_adc2_data),
    .o_adc1_vld  (o_adc1_vld),
    .o_adc2_vld  (o_adc2_vld),
    .o_err       (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int   n_err = 0;
  int   n_chk = 0;
  exp_t sb[$];
  logic [DATA_W-1:0] m_d1, m_d2;
  logic              m_v1, m_v2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge where an ack must be visible.
  task automatic check_ack();
    exp_t e;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("ack_vec", {o_adc2_ack, o_adc1_ack}, e.ch ? 2'b10 : 2'b01);
    chk("err_pulse", o_err, e.err);
    if (!e.err) begin
      if (e.ch) begin m_d2 = e.data; m_v2 = 1'b1; end
      else      begin m_d1 = e.data; m_v1 = 1'b1; end
    end
    chk("adc1_data", o_adc1_data, m_d1);
    chk("adc2_data", o_adc2_data, m_d2);
    chk("adc1_vld", o_adc1_vld, m_v1);
    chk("adc2_vld", o_adc2_vld, m_v2);
    @(negedge i_clk);
    chk("ack_one_cycle", {o_adc2_ack, o_adc1_ack, o_err}, 3'b000);
  endtask

  // mode 0: good response, 1: response with error, 2: no response (timeout).
  task automatic serve(input logic ch, input int ack_dly, input int rsp_dly,
                       input int mode, input logic [DATA_W-1:0] data);
    exp_t e;
    int   n_try;
    for (int i = 0; i < 20 && !owt.o_owt_req; i++) @(negedge i_clk);
    chk("owt_req_seen", owt.o_owt_req, 1);
    chk("owt_ch", owt.o_owt_ch, ch);
    repeat (ack_dly) @(negedge i_clk);
    chk("owt_req_hold", owt.o_owt_req, 1);
    owt.i_owt_ack = 1'b1;
    @(negedge i_clk);
    owt.i_owt_ack = 1'b0;
    chk("owt_req_drop", owt.o_owt_req, 0);
    e.ch = ch; e.err = (mode != 0); e.data = data;
    sb.push_back(e);
    n_try = (mode == 0) ? 1 : N_TRY;
    for (int t = 0; t < n_try; t++) begin
      if (t > 0) begin
        chk("retry_req", owt.o_owt_req, 1);
        owt.i_owt_ack = 1'b1;
        @(negedge i_clk);
        owt.i_owt_ack = 1'b0;
      end
      if (mode == 2) begin
        repeat (TMO_CYC - 1) @(negedge i_clk);
        chk("tmo_not_early", {o_adc2_ack, o_adc1_ack, owt.o_owt_req}, 3'b000);
        @(negedge i_clk);
      end else begin
        repeat (rsp_dly - 1) @(negedge i_clk);
        owt.i_owt_rsp_vld  = 1'b1;
        owt.i_owt_rsp_err  = (mode == 1);
        owt.i_owt_rsp_data = data;
        @(negedge i_clk);
        owt.i_owt_rsp_vld  = 1'b0;
        owt.i_owt_rsp_err  = 1'b0;
        owt.i_owt_rsp_data = '0;
      end
    end
    check_ack();
  endtask

  logic seen_req;

  initial begin
    i_rst_n = 1'b0; i_sched_en = 1'b0; i_adc1_req = 1'b0; i_adc2_req = 1'b0;
    owt.i_owt_ack = 1'b0; owt.i_owt_rsp_vld = 1'b0; owt.i_owt_rsp_err = 1'b0; owt.i_owt_rsp_data = '0;
    m_d1 = '0; m_d2 = '0; m_v1 = 1'b0; m_v2 = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_ctl", {o_adc1_ack, o_adc2_ack, o_err, owt.o_owt_req, owt.o_owt_ch, o_adc1_vld, o_adc2_vld}, 0);
    chk("rst_data", {o_adc1_data, o_adc2_data}, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Both requests held from reset: ADC1 first, then strict alternation.
    i_sched_en = 1'b1; i_adc1_req = 1'b1; i_adc2_req = 1'b1;
    serve(1'b0, 1, 3, 0, 8'h21);
    serve(1'b1, 2, 4, 0, 8'h42);
    serve(1'b0, 0, 2, 0, 8'h63);
    serve(1'b1, 1, 1, 0, 8'h11);
    i_adc1_req = 1'b0; i_adc2_req = 1'b0;
    repeat (2) @(negedge i_clk);

    // ADC1 alone: o_owt_req one cycle after req, ack after 2, response after 5.
    i_adc1_req = 1'b1;
    @(negedge i_clk);
    chk("req_latency", owt.o_owt_req, 1);
    serve(1'b0, 2, 5, 0, 8'hA5);
    i_adc1_req = 1'b0;

    // ADC2 response with CRC error: o_err, data keeps 0x11.
    i_adc2_req = 1'b1;
    serve(1'b1, 1, 3, 1, 8'h3C);
    i_adc2_req = 1'b0;

    // ADC1 timeout: o_err, data keeps 0xA5.
    i_adc1_req = 1'b1;
    serve(1'b0, 1, 0, 2, 8'h00);
    i_adc1_req = 1'b0;

    // ADC2 response exactly on the timeout cycle: response wins.
    i_adc2_req = 1'b1;
    serve(1'b1, 1, TMO_CYC, 0, 8'h7E);
    i_adc2_req = 1'b0;

    // Async reset while waiting for the response.
    i_adc1_req = 1'b1;
    for (int i = 0; i < 20 && !owt.o_owt_req; i++) @(negedge i_clk);
    chk("rst_case_req", owt.o_owt_req, 1);
    owt.i_owt_ack = 1'b1;
    @(negedge i_clk);
    owt.i_owt_ack = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {o_adc1_ack, o_adc2_ack, o_err, owt.o_owt_req, owt.o_owt_ch, o_adc1_vld, o_adc2_vld}, 0);
    chk("midrst_data", {o_adc1_data, o_adc2_data}, 0);
    m_d1 = '0; m_d2 = '0; m_v1 = 1'b0; m_v2 = 1'b0;
    i_sched_en = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    // Scheduler disabled: pending request must not be granted; stray response ignored.
    seen_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      if (owt.o_owt_req || o_adc1_ack || o_adc2_ack) seen_req = 1'b1;
      owt.i_owt_rsp_vld  = (i == 5);
      owt.i_owt_rsp_data = (i == 5) ? 8'h55 : 8'h00;
    end
    chk("disabled_no_grant", seen_req, 0);
    chk("idle_rsp_ignored", {o_adc1_data, o_adc1_vld}, 0);
    chk("sb_empty", sb.size(), 0);

    // Re-enable and confirm normal service resumes.
    i_sched_en = 1'b1;
    serve(1'b0, 1, 2, 0, 8'h5A);
    i_adc1_req = 1'b0;
    repeat (2) @(negedge i_clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
